// File: rtl/mc_pkg.sv
// Shared multi-cycle control definitions: FSM states, mux selects,
// ALU ops and MIPS opcode/funct constants.
package mc_pkg;

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_DCODE = 3'd1;
  localparam logic [2:0] S_EXE   = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;
  localparam logic [3:0] ALU_ADDU = 4'd9;
  localparam logic [3:0] ALU_SUBU = 4'd10;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] GPR_RD = 2'd0;
  localparam logic [1:0] GPR_RT = 2'd1;
  localparam logic [1:0] GPR_RA = 2'd2;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  typedef enum logic [3:0] {
    CLS_ILL,
    CLS_RALU,
    CLS_IALU,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_JAL,
    CLS_JR
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       ext_op;
    logic       areg_sel;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle datapath (master)
// and the mc_ctrl FSM (slave).
interface mc_ctrl_if;
  import mc_pkg::*;

  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       EXTOp;
  logic       ALUSrc;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp;
  logic [1:0] WDSel;
  logic [1:0] GPRSel;
  logic       ARegSel;
  logic       illegal;
  logic [2:0] state;

  modport master (
    output Op, Funct, Zero, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
    input  EXTOp, ALUSrc, ALUOp, NPCOp, WDSel, GPRSel,
    input  ARegSel, illegal, state
  );

  modport slave (
    input  Op, Funct, Zero, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
    output EXTOp, ALUSrc, ALUOp, NPCOp, WDSel, GPRSel,
    output ARegSel, illegal, state
  );

endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: Op/Funct to class,
// ALU op and operand selects.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec.cls      = CLS_ILL;
    dec.alu_op   = ALU_NOP;
    dec.alu_src  = 1'b0;
    dec.ext_op   = 1'b0;
    dec.areg_sel = 1'b0;
    unique case (op)
      OP_R: begin
        dec.cls = CLS_RALU;
        unique case (funct)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_ADDU: dec.alu_op = ALU_ADDU;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_SUBU: dec.alu_op = ALU_SUBU;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          FN_SLL: begin
            dec.alu_op   = ALU_SLL;
            dec.areg_sel = 1'b1;
          end
          FN_SRL: begin
            dec.alu_op   = ALU_SRL;
            dec.areg_sel = 1'b1;
          end
          FN_JR:   dec.cls = CLS_JR;
          default: dec.cls = CLS_ILL;
        endcase
      end
      OP_ADDI: begin
        dec.cls     = CLS_IALU;
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.ext_op  = 1'b1;
      end
      OP_ORI: begin
        dec.cls     = CLS_IALU;
        dec.alu_op  = ALU_OR;
        dec.alu_src = 1'b1;
      end
      OP_LUI: begin
        dec.cls     = CLS_IALU;
        dec.alu_op  = ALU_LUI;
        dec.alu_src = 1'b1;
      end
      OP_LW, OP_SW: begin
        dec.cls     = (op == OP_LW) ? CLS_LW : CLS_SW;
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.ext_op  = 1'b1;
      end
      OP_BEQ: begin
        dec.cls    = CLS_BEQ;
        dec.alu_op = ALU_SUB;
        dec.ext_op = 1'b1;
      end
      OP_J:    dec.cls = CLS_J;
      OP_JAL:  dec.cls = CLS_JAL;
      default: dec.cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DCODE/EXE/MEM/WB).
// Define MC_CTRL_PERF_EN to add instret/cycles counters.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mc_ctrl_if.slave    bus
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] instret,
  output logic [31:0] cycles
`endif
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  dec_t       dec;

  mc_decode u_dec (
    .op    (bus.Op),
    .funct (bus.Funct),
    .dec   (dec)
  );

  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: if (bus.mem_ready) state_d = S_DCODE;
        S_DCODE: begin
          state_d = (dec.cls == CLS_ILL) ? S_FETCH : S_EXE;
        end
        S_EXE: begin
          unique case (dec.cls)
            CLS_RALU, CLS_IALU: state_d = S_WB;
            CLS_LW, CLS_SW:     state_d = S_MEM;
            default:            state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            state_d = (dec.cls == CLS_LW) ? S_WB : S_FETCH;
          end
        end
        S_WB:    state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Everything is forced low while rst is high, whatever state_q holds.
  always_comb begin
    bus.PCWrite  = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.EXTOp    = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.ALUOp    = ALU_NOP;
    bus.NPCOp    = NPC_PC4;
    bus.WDSel    = WD_ALU;
    bus.GPRSel   = GPR_RD;
    bus.ARegSel  = 1'b0;
    bus.illegal  = 1'b0;
    bus.state    = rst ? S_FETCH : state_q;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          bus.MemRead = 1'b1;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        S_DCODE: bus.illegal = (dec.cls == CLS_ILL);
        S_EXE: begin
          bus.ALUOp   = dec.alu_op;
          bus.ALUSrc  = dec.alu_src;
          bus.EXTOp   = dec.ext_op;
          bus.ARegSel = dec.areg_sel;
          unique case (dec.cls)
            CLS_BEQ: begin
              bus.PCWrite = bus.Zero;
              bus.NPCOp   = NPC_BR;
            end
            CLS_J: begin
              bus.PCWrite = 1'b1;
              bus.NPCOp   = NPC_J;
            end
            CLS_JAL: begin
              bus.PCWrite  = 1'b1;
              bus.NPCOp    = NPC_J;
              bus.RegWrite = 1'b1;
              bus.GPRSel   = GPR_RA;
              bus.WDSel    = WD_PC;
            end
            CLS_JR: begin
              bus.PCWrite = 1'b1;
              bus.NPCOp   = NPC_JR;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.MemRead  = (dec.cls == CLS_LW);
          bus.MemWrite = (dec.cls == CLS_SW);
        end
        S_WB: begin
          bus.RegWrite = 1'b1;
          if (dec.cls == CLS_LW) begin
            bus.WDSel  = WD_MEM;
            bus.GPRSel = GPR_RT;
          end else if (dec.cls == CLS_IALU) begin
            bus.GPRSel = GPR_RT;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic retire;

  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_EXE) ||
                   (state_q == S_MEM) ||
                   (state_q == S_WB));

  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
      cycles  <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (retire) instret <= instret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed and random instruction
// streams checked cycle by cycle against a per-instruction trace model.
`timescale 1ns/1ps
module tb_mc_ctrl;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  mc_ctrl_if bus ();

`ifdef MC_CTRL_PERF_EN
  logic [31:0] instret;
  logic [31:0] cycles;
`endif

  mc_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef MC_CTRL_PERF_EN
    ,
    .instret (instret),
    .cycles  (cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_ILL} kind_e;

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [5:0] fn;
    kind_e      k;
    logic [3:0] aop;
    logic       src;
    logic       areg;
    logic       ext;
  } ins_t;

  typedef struct packed {
    logic [2:0] st;
    logic       rdy, zero, alu;
    logic       pcw, irw, rw, mr, mw, ill;
    logic [1:0] npc, wd, gs;
  } step_t;

  ins_t  tbl[$];
  step_t q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t find(string nm);
    foreach (tbl[i]) if (tbl[i].nm == nm) return tbl[i];
    return tbl[0];
  endfunction

  function automatic step_t mk(logic [2:0] st);
    step_t s;
    s      = '0;
    s.st   = st;
    s.rdy  = 1'($urandom);
    s.zero = 1'($urandom);
    return s;
  endfunction

  // Expected cycle trace of one instruction: fw/mwt are wait cycles,
  // zexe forces Zero in EXE (-1 = random).
  task automatic build(ins_t in, int fw, int mwt, int zexe);
    step_t s;
    q.delete();
    for (int i = 0; i < fw; i++) begin
      s = mk(S_FETCH); s.rdy = 1'b0; s.mr = 1'b1;
      q.push_back(s);
    end
    s = mk(S_FETCH);
    s.rdy = 1'b1; s.mr = 1'b1; s.pcw = 1'b1; s.irw = 1'b1;
    q.push_back(s);
    s = mk(S_DCODE);
    s.ill = (in.k == K_ILL);
    q.push_back(s);
    if (in.k == K_ILL) return;
    s = mk(S_EXE);
    s.alu = 1'b1;
    if (zexe >= 0) s.zero = 1'(zexe);
    case (in.k)
      K_BEQ: begin s.pcw = s.zero; s.npc = NPC_BR; end
      K_J:   begin s.pcw = 1'b1;   s.npc = NPC_J;  end
      K_JAL: begin
        s.pcw = 1'b1; s.npc = NPC_J;
        s.rw = 1'b1; s.gs = GPR_RA; s.wd = WD_PC;
      end
      K_JR:  begin s.pcw = 1'b1;   s.npc = NPC_JR; end
      default: ;
    endcase
    q.push_back(s);
    if (in.k inside {K_LW, K_SW}) begin
      for (int i = 0; i <= mwt; i++) begin
        s = mk(S_MEM);
        s.rdy = (i == mwt);
        s.mr  = (in.k == K_LW);
        s.mw  = (in.k == K_SW);
        q.push_back(s);
      end
    end
    if (in.k inside {K_R, K_I, K_LW}) begin
      s = mk(S_WB);
      s.rw = 1'b1;
      s.wd = (in.k == K_LW) ? WD_MEM : WD_ALU;
      s.gs = (in.k == K_R) ? GPR_RD : GPR_RT;
      q.push_back(s);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic run(ins_t in, int fw, int mwt, int zexe, output int lat);
    logic [6:0] alu_exp;
    build(in, fw, mwt, zexe);
    bus.Op    = in.op;
    bus.Funct = in.fn;
    foreach (q[i]) begin
      bus.mem_ready = q[i].rdy;
      bus.Zero      = q[i].zero;
      #1;
      chk({in.nm, ":state"}, 32'(bus.state), 32'(q[i].st));
      chk({in.nm, ":strobes"},
          32'({bus.PCWrite, bus.IRWrite, bus.RegWrite,
               bus.MemRead, bus.MemWrite, bus.illegal}),
          32'({q[i].pcw, q[i].irw, q[i].rw,
               q[i].mr, q[i].mw, q[i].ill}));
      chk({in.nm, ":sel"},
          32'({bus.NPCOp, bus.WDSel, bus.GPRSel}),
          32'({q[i].npc, q[i].wd, q[i].gs}));
      alu_exp = q[i].alu ? {in.aop, in.src, in.areg, in.ext} : 7'd0;
      chk({in.nm, ":alu"},
          32'({bus.ALUOp, bus.ALUSrc, bus.ARegSel, bus.EXTOp}),
          32'(alu_exp));
      @(posedge clk); #1;
    end
    lat = q.size();
  endtask

  task automatic chk_zero(string tag);
    chk(tag,
        32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRead,
             bus.MemWrite, bus.illegal, bus.EXTOp, bus.ALUSrc,
             bus.ARegSel, bus.ALUOp, bus.NPCOp, bus.WDSel,
             bus.GPRSel, bus.state}),
        32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.Zero      = 1'b1;
    #1;
    chk_zero("rst_hold");
    @(posedge clk); #1;
    chk_zero("rst_edge");
    rst = 1'b0;
  endtask

  initial begin
    int   lat;
    int   sum;
    ins_t in;

    tbl.push_back('{"add",  6'h00, 6'h20, K_R,   ALU_ADD,  1'b0, 1'b0, 1'b0});
    tbl.push_back('{"addu", 6'h00, 6'h21, K_R,   ALU_ADDU, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{"sub",  6'h00, 6'h22, K_R,   ALU_SUB,  1'b0, 1'b0, 1'b0});
    tbl.push_back('{"subu", 6'h00, 6'h23, K_R,   ALU_SUBU, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{"and",  6'h00, 6'h24, K_R,   ALU_AND,  1'b0, 1'b0, 1'b0});
    tbl.push_back('{"or",   6'h00, 6'h25, K_R,   ALU_OR,   1'b0, 1'b0, 1'b0});
    tbl.push_back('{"slt",  6'h00, 6'h2a, K_R,   ALU_SLT,  1'b0, 1'b0, 1'b0});
    tbl.push_back('{"sll",  6'h00, 6'h00, K_R,   ALU_SLL,  1'b0, 1'b1, 1'b0});
    tbl.push_back('{"srl",  6'h00, 6'h02, K_R,   ALU_SRL,  1'b0, 1'b1, 1'b0});
    tbl.push_back('{"jr",   6'h00, 6'h08, K_JR,  ALU_NOP,  1'b0, 1'b0, 1'b0});
    tbl.push_back('{"addi", 6'h08, 6'h15, K_I,   ALU_ADD,  1'b1, 1'b0, 1'b1});
    tbl.push_back('{"ori",  6'h0d, 6'h3f, K_I,   ALU_OR,   1'b1, 1'b0, 1'b0});
    tbl.push_back('{"lui",  6'h0f, 6'h01, K_I,   ALU_LUI,  1'b1, 1'b0, 1'b0});
    tbl.push_back('{"lw",   6'h23, 6'h00, K_LW,  ALU_ADD,  1'b1, 1'b0, 1'b1});
    tbl.push_back('{"sw",   6'h2b, 6'h00, K_SW,  ALU_ADD,  1'b1, 1'b0, 1'b1});
    tbl.push_back('{"beq",  6'h04, 6'h00, K_BEQ, ALU_SUB,  1'b0, 1'b0, 1'b1});
    tbl.push_back('{"j",    6'h02, 6'h00, K_J,   ALU_NOP,  1'b0, 1'b0, 1'b0});
    tbl.push_back('{"jal",  6'h03, 6'h00, K_JAL, ALU_NOP,  1'b0, 1'b0, 1'b0});
    tbl.push_back('{"ill",  6'h3f, 6'h00, K_ILL, ALU_NOP,  1'b0, 1'b0, 1'b0});
    tbl.push_back('{"illf", 6'h00, 6'h3f, K_ILL, ALU_NOP,  1'b0, 1'b0, 1'b0});

    bus.Op        = 6'h2b;
    bus.Funct     = 6'h00;
    bus.mem_ready = 1'b0;
    bus.Zero      = 1'b0;
    do_reset();

    run(find("add"),  0, 0,  -1, lat);
    run(find("lw"),   0, 2,  -1, lat);
    run(find("beq"),  0, 0,   1, lat);
    run(find("beq"),  1, 0,   0, lat);
    run(find("ill"),  0, 0,  -1, lat);
    run(find("illf"), 2, 0,  -1, lat);
    run(find("jal"),  0, 0,  -1, lat);
    run(find("sll"),  1, 0,  -1, lat);

    // sw aborted by reset in the middle of its MEM wait.
    bus.Op = 6'h2b; bus.Funct = 6'h00;
    bus.mem_ready = 1'b1; #1;
    chk("sw_rst:fetch", 32'(bus.state), 32'(S_FETCH));
    @(posedge clk); #1; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; #1;
    chk("sw_rst:mem", 32'(bus.state), 32'(S_MEM));
    chk("sw_rst:mw_on", 32'(bus.MemWrite), 32'd1);
    rst = 1'b1; #1;
    chk_zero("sw_rst:hold");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = 1'b0; #1;
      chk("sw_rst:state", 32'(bus.state), 32'(S_FETCH));
      chk("sw_rst:mw_off", 32'(bus.MemWrite), 32'd0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 40; i++) begin
      in = tbl[$urandom_range(tbl.size() - 1)];
      run(in, $urandom_range(2), $urandom_range(2), -1, lat);
    end

`ifdef MC_CTRL_PERF_EN
    do_reset();
    sum = 0;
    run(find("add"), $urandom_range(2), 0, -1, lat);  sum += lat;
    run(find("lw"),  $urandom_range(2), $urandom_range(3), -1, lat); sum += lat;
    run(find("sw"),  $urandom_range(2), $urandom_range(3), -1, lat); sum += lat;
    run(find("beq"), $urandom_range(2), 0, -1, lat);  sum += lat;
    run(find("jal"), $urandom_range(2), 0, -1, lat);  sum += lat;
    chk("perf:instret", instret, 32'd5);
    chk("perf:cycles",  cycles,  32'(sum));
`else
    sum = 0;
`endif

    #1;
    chk("end:state", 32'(bus.state), 32'(S_FETCH));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
